pipe_addsub: RTL

Parametrised, pipelined two's-complement adder/subtractor: the next generation of the 4-bit ripple adder/subtractor. It splits a WIDTH-bit add/subtract into WIDTH/CHUNK registered carry-chain stages and accepts one operation per cycle under a valid/ready handshake. It also returns carry, signed-overflow, zero and negative flags. It sits between operand-producing logic and any accumulator or ALU consumer that needs WIDTH above what a single-cycle ripple chain closes timing at.

---
 rtl/pipe_addsub_if.sv | 29 ++
 rtl/pipe_addsub.sv | 115 +++++++++++
 2 files changed

// File: rtl/pipe_addsub_if.sv
// Handshake and operand/result bundle for the pipelined adder/subtractor.
// The slave modport is the arithmetic block; master is whoever drives operands and consumes results.
interface pipe_addsub_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] res;
  logic             cout;
  logic             ovf;
  logic             zero;
  logic             neg;

  modport slave (
    input  in_valid, a, b, sub, cin, out_ready,
    output in_ready, out_valid, res, cout, ovf, zero, neg
  );

  modport master (
    output in_valid, a, b, sub, cin, out_ready,
    input  in_ready, out_valid, res, cout, ovf, zero, neg
  );
endinterface

// File: rtl/pipe_addsub.sv
// Pipelined two's-complement adder/subtractor: one CHUNK-wide carry-chain slice per stage,
// with carry, signed-overflow, zero and negative flags registered at the last stage.
module pipe_addsub #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic          clk,
  input  logic          rst,
  pipe_addsub_if.slave  bus
);
  localparam int STAGES = WIDTH / CHUNK;
  localparam int LAST   = STAGES - 1;

  logic             adv;
  logic             xfer;

  logic             vld_q [STAGES];
  logic [WIDTH-1:0] a_q   [STAGES];
  logic [WIDTH-1:0] b_q   [STAGES];
  logic [WIDTH-1:0] sum_q [STAGES];
  logic             cy_q  [STAGES];

  logic             vld_d [STAGES];
  logic [WIDTH-1:0] a_d   [STAGES];
  logic [WIDTH-1:0] b_d   [STAGES];
  logic [WIDTH-1:0] sum_d [STAGES];
  logic             cy_d  [STAGES];

  logic [WIDTH-1:0] res_q;
  logic             cout_q, ovf_q, zero_q, neg_q;
  logic             ovf_d, zero_d, msb_cin;

  logic [WIDTH-1:0] a_c, b_c, s_c;
  logic             c_c, v_c;
  logic [CHUNK:0]   chunk;

  // A stalled output freezes the whole pipe; no bubble compression.
  assign adv  = !(vld_q[LAST] && !bus.out_ready);
  assign xfer = bus.in_valid && bus.in_ready;

  assign bus.in_ready  = adv && !rst;
  assign bus.out_valid = vld_q[LAST];
  assign bus.res       = res_q;
  assign bus.cout      = cout_q;
  assign bus.ovf       = ovf_q;
  assign bus.zero      = zero_q;
  assign bus.neg       = neg_q;

  // Each stage resolves its chunk from the previous stage's registers (stage 0 from the bus).
  always_comb begin
    a_c   = bus.a;
    b_c   = bus.b ^ {WIDTH{bus.sub}};
    s_c   = '0;
    c_c   = bus.cin ^ bus.sub;
    v_c   = xfer;
    chunk = '0;
    for (int k = 0; k < STAGES; k++) begin
      chunk = {1'b0, a_c[k*CHUNK +: CHUNK]} + {1'b0, b_c[k*CHUNK +: CHUNK]}
            + {{CHUNK{1'b0}}, c_c};
      a_d[k]   = a_c;
      b_d[k]   = b_c;
      sum_d[k] = s_c;
      sum_d[k][k*CHUNK +: CHUNK] = chunk[CHUNK-1:0];
      cy_d[k]  = chunk[CHUNK];
      vld_d[k] = v_c;
      a_c = a_q[k];
      b_c = b_q[k];
      s_c = sum_q[k];
      c_c = cy_q[k];
      v_c = vld_q[k];
    end
    // Carry into the MSB is recovered from the MSB sum bit and its two operand bits.
    msb_cin = a_d[LAST][WIDTH-1] ^ b_d[LAST][WIDTH-1] ^ sum_d[LAST][WIDTH-1];
    ovf_d   = msb_cin ^ cy_d[LAST];
    zero_d  = (sum_d[LAST] == '0);
  end

  // ---- stage valid bits (control, reset) ----
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) vld_q[k] <= 1'b0;
    end else if (adv) begin
      for (int k = 0; k < STAGES; k++) vld_q[k] <= vld_d[k];
    end
  end

  // ---- inter-stage data (no reset) ----
  always_ff @(posedge clk) begin
    if (adv) begin
      for (int k = 0; k < STAGES; k++) begin
        a_q[k]   <= a_d[k];
        b_q[k]   <= b_d[k];
        sum_q[k] <= sum_d[k];
        cy_q[k]  <= cy_d[k];
      end
    end
  end

  // ---- output register stage ----
  always_ff @(posedge clk) begin
    if (rst) begin
      res_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
      neg_q  <= 1'b0;
    end else if (adv) begin
      res_q  <= sum_d[LAST];
      cout_q <= cy_d[LAST];
      ovf_q  <= ovf_d;
      zero_q <= zero_d;
      neg_q  <= sum_d[LAST][WIDTH-1];
    end
  end
endmodule
